// File: rtl/alu_pkg.sv
// alu_pkg: shared operation codes and FSM state encoding for the execution ALU
package alu_pkg;

    typedef enum logic [2:0] {
        ALU_AND = 3'b000,
        ALU_OR  = 3'b001,
        ALU_ADD = 3'b010,
        ALU_SUB = 3'b110,
        ALU_ROL = 3'b100,
        ALU_ROR = 3'b101
    } alu_ctl_e;

    typedef enum logic [1:0] {
        IDLE,
        ROTATE,
        DONE
    } state_e;

endpackage

// File: rtl/alu_exec_unit_addsub.sv
// alu_addsub: combinational adder/subtractor with carry-out and signed overflow
module alu_addsub #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic             overflow
);

    logic [WIDTH-1:0] bx;

    // Subtraction is a + ~b + 1, so carry-out high means no borrow
    assign bx       = sub ? ~b : b;
    assign {carry, sum} = {1'b0, a} + {1'b0, bx} + {{WIDTH{1'b0}}, sub};
    assign overflow = (a[WIDTH-1] == bx[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);

endmodule

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: handshaked ALU with single-cycle logic/arith and bit-serial rotates
module alu_exec_unit
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int ROT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       alu_ctl,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             carry,
    output logic             overflow,
    output logic             illegal_op
);

    state_e           state;
    alu_ctl_e         ctl;
    logic [ROT_W-1:0] cnt;
    logic [ROT_W-1:0] amt;
    logic             rol;
    logic             sub;
    logic [WIDTH-1:0] sum;
    logic             as_c;
    logic             as_v;
    logic             arith;
    logic             rotate;
    logic             illegal;
    logic [WIDTH-1:0] res_c;
    logic [WIDTH-1:0] rot_nx;
    logic             rot_out;

    assign ctl = alu_ctl_e'(alu_ctl);
    assign amt = op_b[ROT_W-1:0];
    assign sub = (ctl == ALU_SUB);

    alu_addsub #(.WIDTH(WIDTH)) u_addsub (
        .a        (op_a),
        .b        (op_b),
        .sub      (sub),
        .sum      (sum),
        .carry    (as_c),
        .overflow (as_v)
    );

    // Decode the request and form the single-cycle result and the next rotate step
    always_comb begin
        arith   = (ctl == ALU_ADD) || (ctl == ALU_SUB);
        rotate  = (ctl == ALU_ROL) || (ctl == ALU_ROR);
        illegal = !(arith || rotate || ctl == ALU_AND || ctl == ALU_OR);
        res_c   = (ctl == ALU_AND) ? (op_a & op_b) :
                  (ctl == ALU_OR)  ? (op_a | op_b) :
                  arith            ? sum :
                  rotate           ? op_a : '0;
        rot_nx  = rol ? {result[WIDTH-2:0], result[WIDTH-1]} : {result[0], result[WIDTH-1:1]};
        rot_out = rol ? result[WIDTH-1] : result[0];
    end

    // Control FSM; the result register doubles as the rotate working register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            in_ready   <= 1'b1;
            out_valid  <= 1'b0;
            result     <= '0;
            zero       <= 1'b0;
            carry      <= 1'b0;
            overflow   <= 1'b0;
            illegal_op <= 1'b0;
            cnt        <= '0;
            rol        <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    in_ready   <= 1'b0;
                    illegal_op <= illegal;
                    rol        <= (ctl == ALU_ROL);
                    cnt        <= amt;
                    overflow   <= arith && as_v;
                    if (rotate && amt != '0) begin
                        state  <= ROTATE;
                        result <= op_a;
                        carry  <= 1'b0;
                    end else begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                        result    <= res_c;
                        zero      <= (res_c == '0);
                        carry     <= arith && as_c;
                    end
                end
                ROTATE: begin
                    result <= rot_nx;
                    carry  <= rot_out;
                    cnt    <= cnt - ROT_W'(1);
                    if (cnt == ROT_W'(1)) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                        zero      <= (rot_nx == '0);
                    end
                end
                DONE: if (out_ready) begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
- Execution ALU that consumes the 3-bit alu_ctl code produced by the ALU control unit. It operates on two WIDTH-bit operands.
- Handshaked (valid/ready) in both directions. Add/sub/and/or take a single cycle; rotates run iteratively, one bit per cycle.
- Sits between the register-read stage and write-back of the multi-cycle datapath.

Parameters:
- WIDTH, 32, operand/result width in bits.
- ROT_W, $clog2(WIDTH), width of the rotate-amount field, taken from op_b[ROT_W-1:0].

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operation request valid.
- in_ready  output  1  unit can accept a request.
- alu_ctl  input  3  operation code (encoding below).
- op_a  input  WIDTH  operand A; the value rotated for ROL/ROR.
- op_b  input  WIDTH  operand B; rotate amount for ROL/ROR.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- result  output  WIDTH  operation result.
- zero  output  1  result == 0.
- carry  output  1  carry/borrow/rotated-out bit.
- overflow  output  1  signed overflow, add/sub only.
- illegal_op  output  1  alu_ctl was not a defined code.

Behaviour:
- Clock and reset: one clock (clk); reset rst_n is asynchronous, active-low.
- alu_ctl encoding: 000 AND, 001 OR, 010 ADD, 110 SUB, 100 ROL, 101 ROR. Codes 011 and 111 are illegal.
- Reset values: state=IDLE, in_ready=1, out_valid=0, result=0, zero=0, carry=0, overflow=0, illegal_op=0.
- Reset asserted mid-operation aborts it immediately. No result is produced.
- State IDLE:
  - in_ready=1.
  - On in_valid, latch alu_ctl, op_a and rotate amount n = op_b[ROT_W-1:0].
  - ROL/ROR with n>0 -> ROTATE. All other codes -> compute in the same edge and go to DONE.
- State ROTATE:
  - in_ready=0.
  - Each cycle rotate the working register 1 bit and decrement the remaining count.
  - carry takes the bit just rotated out (ROL: old MSB; ROR: old LSB).
  - When remaining reaches 0 -> DONE.
- State DONE:
  - out_valid=1; result and all flags stable.
  - Transfer occurs on out_valid && out_ready -> IDLE.
  - in_ready=0 in DONE. No pipelining: exactly one operation in flight.
- Latency from the accepting edge to out_valid high:
  - Single-cycle ops, and rotates with n=0: 1 cycle.
  - Rotate by n: n+1 cycles.
- Arithmetic rules (modulo 2^WIDTH):
  - ADD: carry = carry-out; overflow = (a[MSB]==b[MSB]) && (r[MSB]!=a[MSB]).
  - SUB: computed as a + ~b + 1; carry = carry-out, so 1 means no borrow; overflow = (a[MSB]!=b[MSB]) && (r[MSB]!=a[MSB]).
  - AND/OR: carry=0, overflow=0.
  - Rotate: overflow=0. With n=0, result=op_a and carry=0.
- Illegal code: result=0, zero=1, carry=0, overflow=0, illegal_op=1, latency 1.
- Flag persistence: illegal_op clears on the next accepted request. All outputs hold their values after the transfer until the next result is written.
- Backpressure: out_ready low holds DONE indefinitely. No input is accepted in that time.
- Input changes: changes on alu_ctl/op_a/op_b outside the accepting edge have no effect.

Decomposition:
- Package alu_pkg holds:
  - typedef enum logic [2:0] alu_ctl_e with ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_ROL, ALU_ROR.
  - typedef enum for FSM states: IDLE, ROTATE, DONE.
- The ALU control unit is updated to use alu_ctl_e.
- One combinational sub-module, alu_addsub (a, b, sub -> sum, carry, overflow), instantiated once.

Test Plan:
- ADD 0x7FFFFFFF + 0x00000001 -> result 0x80000000, overflow=1, carry=0, zero=0, out_valid 1 cycle after accept.
- SUB 0x00000005 - 0x00000005 -> result 0x00000000, zero=1, carry=1, overflow=0. Then SUB 0 - 1 -> 0xFFFFFFFF, carry=0.
- ROL 0x80000001 by op_b=4 -> 0x00000018, carry=0, out_valid exactly 5 cycles after accept, in_ready=0 throughout. ROR 0x00000001 by 1 -> 0x80000000, carry=1, latency 2.
- alu_ctl=3'b011 with op_a=0xFFFF, op_b=0x1 -> result 0, zero=1, illegal_op=1. Next ADD 1+1 -> result 2, illegal_op=0.
- Hold out_ready=0 for 3 cycles after out_valid with AND 0xF0F0F0F0 & 0x0FF00FF0 -> result 0x00F000F0 stable, in_ready=0, a new in_valid is ignored. On out_ready=1 -> IDLE, in_ready=1.
- Start ROL by 31, assert rst_n=0 at cycle 10 -> all outputs at reset values immediately, no out_valid after release. The next request executes normally.
